regfile_wr_arbiter: RTL and testbench

Arbitrates the register file's single write port between two requesters: port A, the core writeback path, and port B, the debug/load-return path. Port A has priority. Port B gets a forced grant once it has waited STARVE_LIMIT cycles. The block registers the winning write for one cycle and then drives reg_write/reg_dst/write_data into the 8x16 register file. It also publishes a per-register busy vector so the sequencer can detect write-after-issue hazards.

---
 rtl/regfile_wr_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Purpose: arbitrates the 8x16 register file write port between A (core writeback, priority) and B (debug/load-return, anti-starvation).
// Latency: a grant in cycle N drives reg_write/reg_dst/write_data in cycle N+1.
// Backpressure: the ready signals are combinational grants; the output stage always drains, so only hold, reset and arbitration deny a request.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   hold                  - suppresses all grants while high
//   a_valid/a_ready/a_dst/a_data, b_valid/b_ready/b_dst/b_data - requester handshakes
//   reg_write/reg_dst/write_data - registered write into the register file
//   busy                  - one-hot of the register being written by the output stage
//   b_starved             - registered flag, high the cycle after a forced B grant
module regfile_wr_arbiter #(
    parameter int DW           = 16,
    parameter int AW           = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [AW-1:0]     a_dst,
    input  logic [DW-1:0]     a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [AW-1:0]     b_dst,
    input  logic [DW-1:0]     b_data,
    output logic              reg_write,
    output logic [AW-1:0]     reg_dst,
    output logic [DW-1:0]     write_data,
    output logic [2**AW-1:0]  busy,
    output logic              b_starved
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]    wait_cnt;
    logic          forced;
    logic          grant_a;
    logic          grant_b;
    logic          grant_any;
    logic [AW-1:0] sel_dst;
    logic [DW-1:0] sel_data;

    // A forced B grant overrides A's priority once B has waited long enough.
    // Reset gates both grants so no handshake completes while state is cleared.
    always_comb begin
        forced  = !reset && !hold && b_valid && (wait_cnt >= LIMIT);
        grant_b = !reset && !hold && b_valid && (forced || !a_valid);
        grant_a = !reset && !hold && a_valid && !forced;
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign grant_any = grant_a || grant_b;
    assign sel_dst   = grant_b ? b_dst  : a_dst;
    assign sel_data  = grant_b ? b_data : a_data;

    // Counts consecutive cycles B was valid but denied; frozen under hold so
    // a hold window neither helps nor hurts B's position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!hold) begin
            if (!b_valid || grant_b) begin
                wait_cnt <= '0;
            end else if (wait_cnt < LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // Output stage. R0 writes still handshake but never raise reg_write, which
    // makes them a silent drop. dst/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write  <= 1'b0;
            reg_dst    <= '0;
            write_data <= '0;
            b_starved  <= 1'b0;
        end else begin
            reg_write <= grant_any && (sel_dst != '0);
            b_starved <= forced;
            if (grant_any) begin
                reg_dst    <= sel_dst;
                write_data <= sel_data;
            end
        end
    end

    always_comb begin
        busy = '0;
        if (reg_write) begin
            busy[reg_dst] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_dst = '0;
    logic [15:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [2:0]  b_dst = '0;
    logic [15:0] b_data = '0;
    logic        reg_write;
    logic [2:0]  reg_dst;
    logic [15:0] write_data;
    logic [7:0]  busy;
    logic        b_starved;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(.DW(16), .AW(3), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .a_valid(a_valid), .a_ready(a_ready), .a_dst(a_dst), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dst(b_dst), .b_data(b_data),
        .reg_write(reg_write), .reg_dst(reg_dst), .write_data(write_data),
        .busy(busy), .b_starved(b_starved)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hold;
        logic        av;
        logic [2:0]  ad;
        logic [15:0] adata;
        logic        bv;
        logic [2:0]  bd;
        logic [15:0] bdata;
        logic        exp_ar;
        logic        exp_br;
        logic        exp_rw;
        logic [2:0]  exp_dst;
        logic [15:0] exp_wd;
        logic [7:0]  exp_busy;
        logic        exp_st;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic h,
                                input logic av, input logic [2:0] ad, input logic [15:0] adata,
                                input logic bv, input logic [2:0] bd, input logic [15:0] bdata,
                                input logic ar, input logic br, input logic rw,
                                input logic [2:0] dst, input logic [15:0] wd,
                                input logic [7:0] bs, input logic st);
        vec_t v;
        v.name = name; v.hold = h;
        v.av = av; v.ad = ad; v.adata = adata;
        v.bv = bv; v.bd = bd; v.bdata = bdata;
        v.exp_ar = ar; v.exp_br = br; v.exp_rw = rw;
        v.exp_dst = dst; v.exp_wd = wd; v.exp_busy = bs; v.exp_st = st;
        return v;
    endfunction

    task automatic drive(input logic h, input logic av, input logic [2:0] ad, input logic [15:0] adata,
                         input logic bv, input logic [2:0] bd, input logic [15:0] bdata);
        hold = h; a_valid = av; a_dst = ad; a_data = adata;
        b_valid = bv; b_dst = bd; b_data = bdata;
    endtask

    initial begin
        // A alone, idle, R0 drop, B alone (wait_cnt cleared afterwards)
        vecs.push_back(mk("a_alone",  0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 1, 0, 1, 3'd3, 16'h1234, 8'h08, 0));
        vecs.push_back(mk("idle",     0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd3, 16'h1234, 8'h00, 0));
        vecs.push_back(mk("r0_drop",  0, 1, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0000, 1, 0, 0, 3'd0, 16'hFFFF, 8'h00, 0));
        vecs.push_back(mk("b_alone",  0, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0B06, 0, 1, 1, 3'd6, 16'h0B06, 8'h40, 0));
        // Contention, STARVE_LIMIT=4: A x4, forced B, repeat
        vecs.push_back(mk("cont_a0",  0, 1, 3'd2, 16'hA000, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA000, 8'h04, 0));
        vecs.push_back(mk("cont_a1",  0, 1, 3'd2, 16'hA001, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA001, 8'h04, 0));
        vecs.push_back(mk("cont_a2",  0, 1, 3'd2, 16'hA002, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA002, 8'h04, 0));
        vecs.push_back(mk("cont_a3",  0, 1, 3'd2, 16'hA003, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA003, 8'h04, 0));
        vecs.push_back(mk("cont_bf",  0, 1, 3'd2, 16'hA004, 1, 3'd7, 16'hBEEF, 0, 1, 1, 3'd7, 16'hBEEF, 8'h80, 1));
        vecs.push_back(mk("cont_a4",  0, 1, 3'd2, 16'hA004, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA004, 8'h04, 0));
        vecs.push_back(mk("cont_a5",  0, 1, 3'd2, 16'hA005, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA005, 8'h04, 0));
        vecs.push_back(mk("cont_a6",  0, 1, 3'd2, 16'hA006, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA006, 8'h04, 0));
        vecs.push_back(mk("cont_a7",  0, 1, 3'd2, 16'hA007, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA007, 8'h04, 0));
        vecs.push_back(mk("cont_bf2", 0, 1, 3'd2, 16'hA008, 1, 3'd7, 16'hBEEF, 0, 1, 1, 3'd7, 16'hBEEF, 8'h80, 1));
        vecs.push_back(mk("cont_a8",  0, 1, 3'd2, 16'hA008, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA008, 8'h04, 0));
        vecs.push_back(mk("cont_a9",  0, 1, 3'd2, 16'hA009, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA009, 8'h04, 0));
        // wait_cnt is now 2; hold three cycles freezes it
        vecs.push_back(mk("hold0",    1, 1, 3'd2, 16'hA00A, 1, 3'd7, 16'hBEEF, 0, 0, 0, 3'd2, 16'hA009, 8'h00, 0));
        vecs.push_back(mk("hold1",    1, 1, 3'd2, 16'hA00A, 1, 3'd7, 16'hBEEF, 0, 0, 0, 3'd2, 16'hA009, 8'h00, 0));
        vecs.push_back(mk("hold2",    1, 1, 3'd2, 16'hA00A, 1, 3'd7, 16'hBEEF, 0, 0, 0, 3'd2, 16'hA009, 8'h00, 0));
        vecs.push_back(mk("rel_a0",   0, 1, 3'd2, 16'hA00A, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA00A, 8'h04, 0));
        vecs.push_back(mk("rel_a1",   0, 1, 3'd2, 16'hA00B, 1, 3'd7, 16'hBEEF, 1, 0, 1, 3'd2, 16'hA00B, 8'h04, 0));
        vecs.push_back(mk("rel_bf",   0, 1, 3'd2, 16'hA00C, 1, 3'd7, 16'hBEEF, 0, 1, 1, 3'd7, 16'hBEEF, 8'h80, 1));
        vecs.push_back(mk("rel_a2",   0, 1, 3'd2, 16'hA00C, 0, 3'd0, 16'h0000, 1, 0, 1, 3'd2, 16'hA00C, 8'h04, 0));
        vecs.push_back(mk("idle2",    0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd2, 16'hA00C, 8'h00, 0));

        // Reset held with both requesters valid
        drive(0, 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_reg_dst", 32'(reg_dst), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_b_starved", 32'(b_starved), 32'd0);

        // First cycle after release grants A
        reset = 1'b0;
        #1;
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        check("post_rst_reg_write", 32'(reg_write), 32'd1);
        check("post_rst_reg_dst", 32'(reg_dst), 32'd1);
        check("post_rst_write_data", 32'(write_data), 32'h1111);
        check("post_rst_busy", 32'(busy), 32'h02);
        // Idle cycle clears B's wait count before the table
        @(negedge clk);
        drive(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
        @(posedge clk); #1;
        check("idle_reg_write", 32'(reg_write), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].hold, vecs[i].av, vecs[i].ad, vecs[i].adata,
                  vecs[i].bv, vecs[i].bd, vecs[i].bdata);
            #1;
            check({vecs[i].name, ".a_ready"}, 32'(a_ready), 32'(vecs[i].exp_ar));
            check({vecs[i].name, ".b_ready"}, 32'(b_ready), 32'(vecs[i].exp_br));
            @(posedge clk); #1;
            check({vecs[i].name, ".reg_write"}, 32'(reg_write), 32'(vecs[i].exp_rw));
            check({vecs[i].name, ".reg_dst"}, 32'(reg_dst), 32'(vecs[i].exp_dst));
            check({vecs[i].name, ".write_data"}, 32'(write_data), 32'(vecs[i].exp_wd));
            check({vecs[i].name, ".busy"}, 32'(busy), 32'(vecs[i].exp_busy));
            check({vecs[i].name, ".b_starved"}, 32'(b_starved), 32'(vecs[i].exp_st));
        end

        // Write committed by the output stage while hold is raised
        @(negedge clk);
        drive(0, 1, 3'd4, 16'h4444, 0, 3'd0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1, 3'd4, 16'h4545, 0, 3'd0, 16'h0000);
        #1;
        check("hold_mid_a_ready", 32'(a_ready), 32'd0);
        check("hold_mid_reg_write", 32'(reg_write), 32'd1);
        check("hold_mid_busy", 32'(busy), 32'h10);
        @(posedge clk); #1;
        check("hold_mid_drain", 32'(reg_write), 32'd0);

        // Reset pulse discards a pending write to R5
        @(negedge clk);
        drive(0, 1, 3'd5, 16'h5555, 0, 3'd0, 16'h0000);
        @(posedge clk); #1;
        check("pre_pulse_busy", 32'(busy), 32'h20);
        drive(0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000);
        reset = 1'b1;
        #1;
        check("pulse_reg_write", 32'(reg_write), 32'd0);
        check("pulse_busy", 32'(busy), 32'h00);
        check("pulse_reg_dst", 32'(reg_dst), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("pulse_after_reg_write", 32'(reg_write), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
